// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button front-end: channel FSM encoding
// and the debounce window lengths used on hardware and in simulation.
package btn_conditioner_pkg;

    // Per-channel debounce FSM encoding (2 bits).
    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms at 100 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_COUNT = 1000000;

    // Short window so simulations finish in a few hundred cycles.
    localparam int unsigned SIM_DEBOUNCE_COUNT = 8;

    // True when the debounced level is high for the given state.
    function automatic logic state_is_high(input btn_state_t st);
        return (st == S_PRESSED) || (st == S_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, debounce counter and
// press/release FSM. The press/release pulses and the level are registered.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// S_RELEASED     | level 0, counter idle; a synced 1 starts a press window
// S_PRESS_WAIT   | counting consecutive synced 1s; any 0 aborts the window
// S_PRESSED      | level 1, counter idle; a synced 0 starts a release window
// S_RELEASE_WAIT | counting consecutive synced 0s; any 1 aborts the window
//
// Legal DEBOUNCE_COUNT range is 2 .. 2**NB_COUNTER-1. The counter is only
// ever compared for equality with DEBOUNCE_COUNT-1, so it cannot wrap.
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned NB_COUNTER     = 32,
    parameter int unsigned DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn_raw,
    output logic o_btn_press,
    output logic o_btn_release,
    output logic o_btn_level
);

    localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_COUNT - 1);
    localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);
    localparam logic [NB_COUNTER-1:0] CNT_ZERO = '0;

    logic                  r_sync_meta;
    logic                  r_sync;

    btn_state_t            r_state;
    btn_state_t            w_state_nxt;
    logic [NB_COUNTER-1:0] r_cnt;
    logic [NB_COUNTER-1:0] w_cnt_nxt;
    logic                  r_level;
    logic                  w_level_nxt;
    logic                  r_press;
    logic                  w_press_nxt;
    logic                  r_release;
    logic                  w_release_nxt;

    logic                  w_cnt_done;

    assign w_cnt_done = (r_cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= i_btn_raw;
            r_sync      <= r_sync_meta;
        end
    end

    // FSM state, debounce counter, level and pulse registers.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_state   <= S_RELEASED;
            r_cnt     <= CNT_ZERO;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Next-state logic: count consecutive cycles of the new level on the
    // synced input, abort back to the stable state on any bounce.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = state_is_high(r_state);
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;

        case (r_state)
            S_RELEASED: begin
                w_cnt_nxt = CNT_ZERO;
                if (r_sync) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end

            S_PRESS_WAIT: begin
                if (!r_sync) begin
                    w_state_nxt = S_RELEASED;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (w_cnt_done) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = CNT_ZERO;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_PRESSED: begin
                w_cnt_nxt = CNT_ZERO;
                if (!r_sync) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end

            S_RELEASE_WAIT: begin
                if (r_sync) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (w_cnt_done) begin
                    w_state_nxt   = S_RELEASED;
                    w_cnt_nxt     = CNT_ZERO;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = S_RELEASED;
                w_cnt_nxt   = CNT_ZERO;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign o_btn_press   = r_press;
    assign o_btn_release = r_release;
    assign o_btn_level   = r_level;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front-end: one independent debounce channel per button pin,
// producing a one-cycle press pulse, a one-cycle release pulse and a clean
// level for each button.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned NB_BTN         = 4,
    parameter int unsigned NB_COUNTER     = 32,
    parameter int unsigned DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn_raw,
    output logic [NB_BTN-1:0] o_btn_press,
    output logic [NB_BTN-1:0] o_btn_release,
    output logic [NB_BTN-1:0] o_btn_level
);

    logic [NB_BTN-1:0] w_press;
    logic [NB_BTN-1:0] w_release;
    logic [NB_BTN-1:0] w_level;

    for (genvar g = 0; g < NB_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .NB_COUNTER     (NB_COUNTER),
            .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
        ) u_ch (
            .clock         (clock),
            .i_reset       (i_reset),
            .i_btn_raw     (i_btn_raw[g]),
            .o_btn_press   (w_press[g]),
            .o_btn_release (w_release[g]),
            .o_btn_level   (w_level[g])
        );
    end

    assign o_btn_press   = w_press;
    assign o_btn_release = w_release;
    assign o_btn_level   = w_level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with a short debounce window. Each stimulus
// segment holds the inputs for a number of cycles and states what the
// outputs must be in every one of those cycles; the expectations go into a
// queue as the inputs are driven and are compared on the falling edge.
module tb_btn_conditioner;
    import btn_conditioner_pkg::*;

    localparam int NB_BTN = 4;

    logic              clock = 1'b0;
    logic              i_reset;
    logic [NB_BTN-1:0] i_btn_raw;
    logic [NB_BTN-1:0] o_btn_press;
    logic [NB_BTN-1:0] o_btn_release;
    logic [NB_BTN-1:0] o_btn_level;

    btn_conditioner #(
        .NB_BTN         (NB_BTN),
        .NB_COUNTER     (32),
        .DEBOUNCE_COUNT (SIM_DEBOUNCE_COUNT)
    ) dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_btn_raw     (i_btn_raw),
        .o_btn_press   (o_btn_press),
        .o_btn_release (o_btn_release),
        .o_btn_level   (o_btn_level)
    );

    always #5 clock = ~clock;

    typedef struct {
        string             name;
        logic              rst_n;
        logic [NB_BTN-1:0] raw;
        int                len;
        logic [NB_BTN-1:0] press;
        logic [NB_BTN-1:0] rel;
        logic [NB_BTN-1:0] lvl;
    } seg_t;

    typedef struct {
        string             name;
        logic [NB_BTN-1:0] press;
        logic [NB_BTN-1:0] rel;
        logic [NB_BTN-1:0] lvl;
    } exp_t;

    seg_t tbl[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Hold inputs for len cycles, queueing the expected outputs per cycle.
    task automatic drive_seg(input string name, input logic rst_n,
                             input logic [NB_BTN-1:0] raw, input int len,
                             input logic [NB_BTN-1:0] p,
                             input logic [NB_BTN-1:0] r,
                             input logic [NB_BTN-1:0] l);
        exp_t e;
        for (int c = 0; c < len; c++) begin
            @(posedge clock);
            #1;
            i_reset   = rst_n;
            i_btn_raw = raw;
            e.name  = name;
            e.press = p;
            e.rel   = r;
            e.lvl   = l;
            sb_q.push_back(e);
        end
    endtask

    // Scoreboard: compare the DUT against the oldest queued expectation.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if (o_btn_press !== mon_e.press || o_btn_release !== mon_e.rel ||
                o_btn_level !== mon_e.lvl) begin
                n_errors++;
                $display("FAIL %s @%0t: got press=%b release=%b level=%b, expected press=%b release=%b level=%b",
                         mon_e.name, $time, o_btn_press, o_btn_release, o_btn_level,
                         mon_e.press, mon_e.rel, mon_e.lvl);
            end
            n_checks++;
            if ((o_btn_press & o_btn_release) != '0) begin
                n_errors++;
                $display("FAIL pulse_overlap @%0t: got press=%b release=%b, expected no common bit",
                         $time, o_btn_press, o_btn_release);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int drain;

        // 1: reset with all buttons held, then one press on every channel.
        tbl.push_back('{"t1_in_reset",     1'b0, 4'hF,  3, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t1_wait",         1'b1, 4'hF, 10, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t1_press",        1'b1, 4'hF,  1, 4'hF, 4'h0, 4'hF});
        tbl.push_back('{"t1_hold",         1'b1, 4'hF,  5, 4'h0, 4'h0, 4'hF});
        tbl.push_back('{"t1_rel_wait",     1'b1, 4'h0, 10, 4'h0, 4'h0, 4'hF});
        tbl.push_back('{"t1_release",      1'b1, 4'h0,  1, 4'h0, 4'hF, 4'h0});
        tbl.push_back('{"t1_idle",         1'b1, 4'h0,  5, 4'h0, 4'h0, 4'h0});
        // 2: clean press at cycle 0, release at cycle 40 on bit 0.
        tbl.push_back('{"t2_wait",         1'b1, 4'h1, 10, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t2_press",        1'b1, 4'h1,  1, 4'h1, 4'h0, 4'h1});
        tbl.push_back('{"t2_hold",         1'b1, 4'h1, 29, 4'h0, 4'h0, 4'h1});
        tbl.push_back('{"t2_rel_wait",     1'b1, 4'h0, 10, 4'h0, 4'h0, 4'h1});
        tbl.push_back('{"t2_release",      1'b1, 4'h0,  1, 4'h0, 4'h1, 4'h0});
        tbl.push_back('{"t2_idle",         1'b1, 4'h0,  5, 4'h0, 4'h0, 4'h0});
        // 3: bouncing bit 1, then a steady press.
        tbl.push_back('{"t3_bounce_hi1",   1'b1, 4'h2,  3, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t3_bounce_lo1",   1'b1, 4'h0,  3, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t3_bounce_hi2",   1'b1, 4'h2,  3, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t3_bounce_lo2",   1'b1, 4'h0,  3, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t3_wait",         1'b1, 4'h2, 10, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t3_press",        1'b1, 4'h2,  1, 4'h2, 4'h0, 4'h2});
        tbl.push_back('{"t3_hold",         1'b1, 4'h2,  5, 4'h0, 4'h0, 4'h2});
        tbl.push_back('{"t3_rel_wait",     1'b1, 4'h0, 10, 4'h0, 4'h0, 4'h2});
        tbl.push_back('{"t3_release",      1'b1, 4'h0,  1, 4'h0, 4'h2, 4'h0});
        tbl.push_back('{"t3_idle",         1'b1, 4'h0,  3, 4'h0, 4'h0, 4'h0});
        // 4: bit 2 high for 7 cycles (rejected), then for 8 (accepted).
        tbl.push_back('{"t4_glitch7",      1'b1, 4'h4,  7, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t4_after7",       1'b1, 4'h0, 12, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t4_high8",        1'b1, 4'h4,  8, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t4_after8",       1'b1, 4'h0,  2, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t4_press8",       1'b1, 4'h0,  1, 4'h4, 4'h0, 4'h4});
        tbl.push_back('{"t4_rel_wait",     1'b1, 4'h0,  7, 4'h0, 4'h0, 4'h4});
        tbl.push_back('{"t4_release",      1'b1, 4'h0,  1, 4'h0, 4'h4, 4'h0});
        tbl.push_back('{"t4_idle",         1'b1, 4'h0,  3, 4'h0, 4'h0, 4'h0});
        // 5: reset while bit 3 is mid-count, button held through it.
        tbl.push_back('{"t5_count",        1'b1, 4'h8,  7, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t5_reset",        1'b0, 4'h8,  3, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t5_wait",         1'b1, 4'h8, 10, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t5_press",        1'b1, 4'h8,  1, 4'h8, 4'h0, 4'h8});
        tbl.push_back('{"t5_hold",         1'b1, 4'h8,  3, 4'h0, 4'h0, 4'h8});
        tbl.push_back('{"t5_rel_wait",     1'b1, 4'h0, 10, 4'h0, 4'h0, 4'h8});
        tbl.push_back('{"t5_release",      1'b1, 4'h0,  1, 4'h0, 4'h8, 4'h0});
        tbl.push_back('{"t5_idle",         1'b1, 4'h0,  3, 4'h0, 4'h0, 4'h0});
        // 6: bits 0+3 together, bit 1 two cycles later, long hold.
        tbl.push_back('{"t6_wait_a",       1'b1, 4'h9,  2, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t6_wait_b",       1'b1, 4'hB,  8, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{"t6_press_09",     1'b1, 4'hB,  1, 4'h9, 4'h0, 4'h9});
        tbl.push_back('{"t6_gap",          1'b1, 4'hB,  1, 4'h0, 4'h0, 4'h9});
        tbl.push_back('{"t6_press_02",     1'b1, 4'hB,  1, 4'h2, 4'h0, 4'hB});
        tbl.push_back('{"t6_no_repeat",    1'b1, 4'hB,100, 4'h0, 4'h0, 4'hB});
        tbl.push_back('{"t6_rel_wait",     1'b1, 4'h0, 10, 4'h0, 4'h0, 4'hB});
        tbl.push_back('{"t6_release",      1'b1, 4'h0,  1, 4'h0, 4'hB, 4'h0});
        tbl.push_back('{"t6_idle",         1'b1, 4'h0,  3, 4'h0, 4'h0, 4'h0});

        i_reset   = 1'b0;
        i_btn_raw = '0;
        repeat (2) @(posedge clock);

        foreach (tbl[k]) begin
            drive_seg(tbl[k].name, tbl[k].rst_n, tbl[k].raw, tbl[k].len,
                      tbl[k].press, tbl[k].rel, tbl[k].lvl);
        end

        // Bounce when the counter has reached DEBOUNCE_COUNT-2: the window
        // restarts and the full count is needed from the next rise.
        drive_seg("h1_count6",     1'b1, 4'h1,  6, 4'h0, 4'h0, 4'h0);
        drive_seg("h1_bounce",     1'b1, 4'h0,  2, 4'h0, 4'h0, 4'h0);
        drive_seg("h1_wait",       1'b1, 4'h1, 10, 4'h0, 4'h0, 4'h0);
        drive_seg("h1_press",      1'b1, 4'h1,  1, 4'h1, 4'h0, 4'h1);
        drive_seg("h1_hold",       1'b1, 4'h1,  2, 4'h0, 4'h0, 4'h1);

        // Reset while the level is high clears it without a release pulse.
        drive_seg("h2_rst_edge",   1'b0, 4'h1,  1, 4'h0, 4'h0, 4'h1);
        drive_seg("h2_in_reset",   1'b0, 4'h0,  2, 4'h0, 4'h0, 4'h0);
        drive_seg("h2_no_release", 1'b1, 4'h0, 12, 4'h0, 4'h0, 4'h0);

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        @(posedge clock);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
